// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the memory bridge slice.
// Contents: resp_t, the 2-bit AXI response code carried on bresp/rresp.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

endpackage

// File: rtl/axi_lite_resp_fifo.sv
// Synchronous response FIFO used for the B and R return paths of the bridge.
// Ports:
//   clk, rstn        clock, synchronous active-low reset (clears pointers/count)
//   push, din        write side; push while full is accepted only with a pop
//   pop, dout        read side; dout shows the head entry whenever not empty
//   full, empty      occupancy flags
//   count            current occupancy, 0..DEPTH
module axi_lite_resp_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_pop  = pop & ~empty;
    // When full, a push only lands if the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rstn) push |-> (!full || pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rstn) pop |-> !empty);

endmodule

// File: rtl/axi4_lite_mem_bridge.sv
// AXI4-Lite slave to SRAM bridge with separate write and read memory ports.
// Ports:
//   clk, rstn                         clock, synchronous active-low reset
//   aw*/w*/b*                         AXI-Lite write address, data, response channels
//   ar*/r*                            AXI-Lite read address and data channels
//   mem_we/mem_waddr/mem_wdata/mem_wstrb   memory write port (zero when idle)
//   mem_re/mem_raddr                  memory read request
//   mem_rdata                         memory read data, valid RD_LAT cycles after mem_re
// Writes issue in the cycle both address and data are available (live or held);
// reads are tagged through an RD_LAT-deep pipeline and returned in order.
// Addresses beyond the memory decode to DECERR and never reach the memory.
module axi4_lite_mem_bridge
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_AW  = 10,
    parameter int RD_LAT  = 1,
    parameter int B_DEPTH = 4,
    parameter int R_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_W-1:0]     araddr,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_waddr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic                  mem_re,
    output logic [MEM_AW-1:0]     mem_raddr,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int ALIGN  = $clog2(STRB_W);
    localparam int BCW    = $clog2(B_DEPTH) + 1;
    localparam int RCW    = $clog2(R_DEPTH) + 1;

    if (ADDR_W < MEM_AW + ALIGN) begin : g_bad_addr_w
        $error("ADDR_W too small for MEM_AW plus byte offset");
    end
    if (RD_LAT < 1 || R_DEPTH < RD_LAT + 1) begin : g_bad_rd_cfg
        $error("RD_LAT must be >= 1 and R_DEPTH >= RD_LAT+1");
    end

    // Any set bit above the memory's byte range is a decode error.
    function automatic logic addr_oor(input logic [ADDR_W-1:0] a);
        return (a >> (MEM_AW + ALIGN)) != '0;
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return MEM_AW'(a >> ALIGN);
    endfunction

    // ---------------------------------------------------------------- write
    logic                aw_held;
    logic                w_held;
    logic [ADDR_W-1:0]   aw_addr_h;
    logic [DATA_W-1:0]   w_data_h;
    logic [STRB_W-1:0]   w_strb_h;
    logic                b_room;
    logic                aw_hs;
    logic                w_hs;
    logic                wr_issue;
    logic                wr_err;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [STRB_W-1:0]   wr_strb;
    logic [1:0]          b_din;
    logic [1:0]          b_dout;
    logic                b_pop;
    logic                b_full;
    logic                b_empty;
    logic [BCW-1:0]      b_cnt;

    // Write credit: never accept a beat whose response could not be queued.
    assign b_room   = b_cnt < BCW'(B_DEPTH);
    assign awready  = rstn & ~aw_held & b_room;
    assign wready   = rstn & ~w_held & b_room;
    assign aw_hs    = awvalid & awready;
    assign w_hs     = wvalid & wready;
    assign wr_issue = (aw_held | aw_hs) & (w_held | w_hs);

    assign wr_addr  = aw_held ? aw_addr_h : awaddr;
    assign wr_data  = w_held  ? w_data_h  : wdata;
    assign wr_strb  = w_held  ? w_strb_h  : wstrb;
    assign wr_err   = addr_oor(wr_addr);
    assign b_din    = wr_err ? DECERR : OKAY;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else if (wr_issue) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) aw_held <= 1'b1;
            if (w_hs)  w_held  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs && !wr_issue) aw_addr_h <= awaddr;
        if (w_hs && !wr_issue) begin
            w_data_h <= wdata;
            w_strb_h <= wstrb;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (wr_issue && !wr_err) begin
            mem_we    = 1'b1;
            mem_waddr = word_idx(wr_addr);
            mem_wdata = wr_data;
            mem_wstrb = wr_strb;
        end
    end

    axi_lite_resp_fifo #(.WIDTH(2), .DEPTH(B_DEPTH)) u_b_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (wr_issue),
        .din   (b_din),
        .pop   (b_pop),
        .dout  (b_dout),
        .full  (b_full),
        .empty (b_empty),
        .count (b_cnt)
    );

    assign bvalid = rstn & ~b_empty;
    assign b_pop  = bvalid & bready;
    assign bresp  = bvalid ? b_dout : OKAY;

    // ----------------------------------------------------------------- read
    logic                 ar_hs;
    logic                 rd_err;
    logic [RCW-1:0]       r_cnt;
    logic [RD_LAT-1:0]    rd_vld_p;
    logic [RD_LAT-1:0]    rd_err_p;
    logic                 r_push;
    logic [DATA_W-1:0]    r_data_p;
    logic [1:0]           r_resp_p;
    logic [DATA_W+1:0]    r_dout;
    logic                 r_pop;
    logic                 r_full;
    logic                 r_empty;
    logic [RCW-1:0]       r_count;

    // r_cnt covers reads in the tag pipeline and in the R FIFO, so a granted
    // AR always has a FIFO slot waiting when its data returns.
    assign arready   = rstn & (r_cnt < RCW'(R_DEPTH));
    assign ar_hs     = arvalid & arready;
    assign rd_err    = addr_oor(araddr);
    assign mem_re    = ar_hs & ~rd_err;
    assign mem_raddr = mem_re ? word_idx(araddr) : '0;

    // Stage boundary: AR accepted, tag enters the RD_LAT-deep shift register.
    always_ff @(posedge clk) begin
        if (!rstn) rd_vld_p <= '0;
        else       rd_vld_p <= (rd_vld_p << 1) | RD_LAT'(ar_hs);
    end

    always_ff @(posedge clk) begin
        rd_err_p <= (rd_err_p << 1) | RD_LAT'(rd_err);
    end

    // Stage boundary: tag reaches the last stage together with mem_rdata.
    assign r_push   = rd_vld_p[RD_LAT-1];
    assign r_data_p = rd_err_p[RD_LAT-1] ? {DATA_W{1'b0}} : mem_rdata;
    assign r_resp_p = rd_err_p[RD_LAT-1] ? DECERR : OKAY;

    axi_lite_resp_fifo #(.WIDTH(DATA_W+2), .DEPTH(R_DEPTH)) u_r_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (r_push),
        .din   ({r_data_p, r_resp_p}),
        .pop   (r_pop),
        .dout  (r_dout),
        .full  (r_full),
        .empty (r_empty),
        .count (r_count)
    );

    assign rvalid = rstn & ~r_empty;
    assign r_pop  = rvalid & rready;
    assign rdata  = rvalid ? r_dout[DATA_W+1:2] : '0;
    assign rresp  = rvalid ? r_dout[1:0] : OKAY;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else begin
            case ({ar_hs, r_pop})
                2'b10:   r_cnt <= r_cnt + RCW'(1);
                2'b01:   r_cnt <= r_cnt - RCW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    a_r_cnt_max:   assert property (@(posedge clk) disable iff (!rstn) r_cnt <= RCW'(R_DEPTH));
    a_r_fifo_cov:  assert property (@(posedge clk) disable iff (!rstn) r_count <= r_cnt);
    a_r_no_ovf:    assert property (@(posedge clk) disable iff (!rstn) !(r_push && r_full && !r_pop));
    a_b_no_ovf:    assert property (@(posedge clk) disable iff (!rstn) wr_issue |-> (!b_full || b_pop));

endmodule
